// File: rtl/async_fifo_pkg.sv
// Shared defaults and the binary-to-Gray helper for the async_fifo block.
// Pointer code that crosses clock boundaries is always handled in Gray form.
package async_fifo_pkg;

  localparam int DSIZE_DEFAULT = 32;
  localparam int ASIZE_DEFAULT = 4;

  // Callers size the argument up to 32 bits and truncate the result back.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// FIFO storage: 2**ASIZE x DSIZE words, synchronous write, asynchronous read.
// Contents are deliberately not reset; the pointers decide what is valid.
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEFAULT,
  parameter int ASIZE = ASIZE_DEFAULT
) (
  input  logic             wclk_i,
  input  logic             wen_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];

  always_ff @(posedge wclk_i) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/async_fifo.sv
// Gray-pointer FIFO with two-flop pointer synchronizers and registered flags.
// Both sides run on wclk; the synchronizer chains keep the classic flag latency.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEFAULT,
  parameter int ASIZE = ASIZE_DEFAULT
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
);

  localparam int PW = ASIZE + 1;
  // Full when the write Gray pointer equals the read pointer with its two MSBs flipped.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ASIZE - 1);

  // Handshake: winc/rinc are the valid side, ~wfull/~rempty the ready side; a
  // transfer happens only on an edge where both are high, so requests may be
  // held across a full or empty condition without side effects.

  logic [PW-1:0] wbin_q, wbin_d, wptr_q, wptr_d;
  logic [PW-1:0] rbin_q, rbin_d, rptr_q, rptr_d;
  logic [PW-1:0] wq1_rptr_q, wq2_rptr_q;
  logic [PW-1:0] rq1_wptr_q, rq2_wptr_q;
  logic          wfull_q, wfull_d;
  logic          rempty_q, rempty_d;
  logic          w_accept, r_accept;

  assign w_accept = winc & ~wfull_q;
  assign r_accept = rinc & ~rempty_q;

  always_comb begin
    wbin_d   = wbin_q + PW'(w_accept);
    wptr_d   = PW'(bin2gray(32'(wbin_d)));
    wfull_d  = (wptr_d == (wq2_rptr_q ^ FULL_MASK));
    rbin_d   = rbin_q + PW'(r_accept);
    rptr_d   = PW'(bin2gray(32'(rbin_d)));
    rempty_d = (rptr_d == rq2_wptr_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q     <= '0;
      wptr_q     <= '0;
      rbin_q     <= '0;
      rptr_q     <= '0;
      wq1_rptr_q <= '0;
      wq2_rptr_q <= '0;
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
      wfull_q    <= 1'b0;
      rempty_q   <= 1'b1;
    end else begin
      wbin_q     <= wbin_d;
      wptr_q     <= wptr_d;
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      wq1_rptr_q <= rptr_q;
      wq2_rptr_q <= wq1_rptr_q;
      rq1_wptr_q <= wptr_q;
      rq2_wptr_q <= rq1_wptr_q;
      wfull_q    <= wfull_d;
      rempty_q   <= rempty_d;
    end
  end

  async_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .wclk_i  (wclk),
    .wen_i   (w_accept),
    .waddr_i (wbin_q[ASIZE-1:0]),
    .wdata_i (wdata),
    .raddr_i (rbin_q[ASIZE-1:0]),
    .rdata_o (rdata)
  );

  assign wfull  = wfull_q;
  assign rempty = rempty_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: flag latency, ordering across wrap, full/empty
// boundaries and asynchronous reset, with an expected-data queue.
module tb_async_fifo;

  localparam int DSIZE = 32;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             wclk   = 1'b0;
  logic             wrst_n = 1'b0;
  logic             winc   = 1'b0;
  logic             rinc   = 1'b0;
  logic [DSIZE-1:0] wdata  = '0;
  logic             wfull;
  logic             rempty;
  logic [DSIZE-1:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DSIZE-1:0] exp_q[$];

  // clock / reset
  always #5 wclk = ~wclk;

  async_fifo #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    winc  = 1'b1;
    wdata = d;
    exp_q.push_back(d);
    tick();
  endtask

  task automatic rd(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({tag, "_rempty"}, 32'(rempty), 32'd0);
    check({tag, "_rdata"}, rdata, e);
    rinc = 1'b1;
    tick();
  endtask

  task automatic wait_not_empty(input string tag, input int budget);
    int cycles;
    cycles = 0;
    while (rempty && cycles < budget) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'd3);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset held, then idle
    repeat (3) tick();
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_wfull", 32'(wfull), 32'd0);
    wrst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_rempty", 32'(rempty), 32'd1);
      check("idle_wfull", 32'(wfull), 32'd0);
    end

    // single word, exact empty-flag latency
    wr(32'h0000_000A);
    winc = 1'b0;
    check("single_n0", 32'(rempty), 32'd1);
    tick();
    check("single_n1", 32'(rempty), 32'd1);
    tick();
    check("single_n2", 32'(rempty), 32'd1);
    tick();
    check("single_n3", 32'(rempty), 32'd0);
    rd("single");
    rinc = 1'b0;
    check("single_empty", 32'(rempty), 32'd1);

    // read while empty must not move the read pointer
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("empty_rd_ignored", 32'(rempty), 32'd1);
    wr(32'h0000_0077);
    winc = 1'b0;
    wait_not_empty("after_empty_rd", 6);
    rd("after_empty_rd");
    rinc = 1'b0;

    // one-at-a-time stream across the address wrap
    for (int v = 0; v < 20; v++) begin
      wr(32'(v));
      winc = 1'b0;
      wait_not_empty("stream", 6);
      rd("stream");
      rinc = 1'b0;
    end
    check("stream_empty", 32'(rempty), 32'd1);

    // fill to full, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) begin
      wr(32'(i));
      if (i == DEPTH - 2) check("fill_not_full_15", 32'(wfull), 32'd0);
    end
    check("fill_full_16", 32'(wfull), 32'd1);
    wdata = 32'hDEAD_BEEF;
    tick();
    winc = 1'b0;
    check("overflow_full", 32'(wfull), 32'd1);
    for (int i = 0; i < DEPTH; i++) rd("fill_rd");
    rinc = 1'b0;
    check("drain_empty", 32'(rempty), 32'd1);
    check("drain_not_full", 32'(wfull), 32'd0);

    // full-flag release latency and refill
    for (int i = 0; i < DEPTH; i++) wr(32'(100 + i));
    winc = 1'b0;
    check("refill_full", 32'(wfull), 32'd1);
    rd("one_from_full");
    rinc = 1'b0;
    check("full_n0", 32'(wfull), 32'd1);
    tick();
    check("full_n1", 32'(wfull), 32'd1);
    tick();
    check("full_n2", 32'(wfull), 32'd1);
    tick();
    check("full_n3", 32'(wfull), 32'd0);
    wr(32'd116);
    winc = 1'b0;
    check("refull", 32'(wfull), 32'd1);
    for (int i = 0; i < DEPTH; i++) rd("refill_rd");
    rinc = 1'b0;
    check("refill_empty", 32'(rempty), 32'd1);

    // asynchronous reset with 8 words stored
    for (int i = 0; i < 8; i++) wr(32'(200 + i));
    winc = 1'b0;
    repeat (3) tick();
    check("pre_rst_rempty", 32'(rempty), 32'd0);
    wrst_n = 1'b0;
    #2;
    check("async_rst_rempty", 32'(rempty), 32'd1);
    check("async_rst_wfull", 32'(wfull), 32'd0);
    exp_q.delete();
    tick();
    wrst_n = 1'b1;
    wr(32'h0000_0005);
    winc = 1'b0;
    wait_not_empty("post_rst", 6);
    rd("post_rst");
    rinc = 1'b0;
    check("post_rst_empty", 32'(rempty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 SHALL have parameter DSIZE, default 32, data word width in bits.
REQ-002 SHALL have parameter ASIZE, default 4, address width; depth = 2**ASIZE (16 words).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 wclk  input  1  sole clock; all state updates on its rising edge.
REQ-005 wrst_n  input  1  asynchronous active-low reset of the whole block.
REQ-006 winc  input  1  write request; sampled on rising wclk.
REQ-007 wdata  input  DSIZE  write data, captured with winc.
REQ-008 wfull  output  1  registered full flag.
REQ-009 rinc  input  1  read (pop) request; sampled on rising wclk.
REQ-010 rdata  output  DSIZE  head-of-FIFO word, first-word-fall-through.
REQ-011 rempty  output  1  registered empty flag.
REQ-012 Port order SHALL be wclk, wrst_n, winc, wdata, wfull, rinc, rdata, rempty; parameter order DSIZE, ASIZE.

Function
REQ-013 Write SHALL occur on a rising edge when winc=1 and wfull=0: mem[waddr]<=wdata, write pointer +1.
REQ-014 winc with wfull=1 SHALL be ignored: no memory write, no pointer change, stored data intact.
REQ-015 Read SHALL occur on a rising edge when rinc=1 and rempty=0: read pointer +1.
REQ-016 rinc with rempty=1 SHALL be ignored.
REQ-017 rdata SHALL be combinational mem[raddr]: valid whenever rempty=0, without asserting rinc; undefined while rempty=1.
REQ-018 Pointers SHALL be ASIZE+1 bits, binary and Gray copies; addresses are the low ASIZE binary bits; wrap modulo 2**(ASIZE+1).
REQ-019 Each pointer's Gray value SHALL pass through a 2-flop register chain to the opposite side (wq2_rptr, rq2_wptr).
REQ-020 rempty SHALL be registered: next value = (next read Gray pointer == rq2_wptr).
REQ-021 wfull SHALL be registered: next value = (next write Gray pointer == wq2_rptr with its two MSBs inverted).
REQ-022 Latency: write at edge N into empty FIFO -> rempty falls at edge N+3; rdata valid from then.
REQ-023 The write that stores the 16th word SHALL assert wfull on that same edge; a read at edge N from full -> wfull falls at edge N+3.
REQ-024 Simultaneous winc and rinc SHALL each be evaluated independently against the current registered flags.
REQ-025 Flags SHALL be conservative: never report not-full when full nor not-empty when empty; late deassertion is allowed.
REQ-026 FIFO order SHALL be strict: words read in write order, none lost or duplicated across pointer wrap.

Reset
REQ-027 wrst_n=0 SHALL immediately clear all pointers and synchronizer stages, set rempty=1 and wfull=0.
REQ-028 Memory SHALL NOT be reset; reset mid-operation discards all contents.
REQ-029 Reset release SHALL be usable at any time; first write is accepted on the first rising edge with wrst_n=1.

Structure
REQ-030 Package async_fifo_pkg SHALL hold default DSIZE/ASIZE constants and bin2gray function.
REQ-031 One sub-module async_fifo_mem SHALL implement the 2**ASIZE x DSIZE RAM: synchronous write, asynchronous read.
REQ-032 Pointer/flag logic and synchronizers SHALL live in async_fifo; target 120-400 lines total.

Verification
REQ-033 Reset, idle: after release -> wfull=0, rempty=1 held indefinitely.
REQ-034 Single write 0x0000000A -> rempty falls 3 edges later, rdata=0x0000000A; one rinc -> rempty=1.
REQ-035 Write then read values 0..19 one at a time (crosses pointer wrap) -> each rdata equals the value written.
REQ-036 16 consecutive writes 0..15 -> wfull=1 on 16th write edge; 17th write 0xDEADBEEF ignored; 16 reads return 0..15, then rempty=1.
REQ-037 From full, one read -> wfull=0 after 3 edges; one write accepted -> wfull=1 again.
REQ-038 Assert wrst_n=0 with 8 words stored -> rempty=1, wfull=0 asynchronously; subsequent write/read of 0x5 returns 0x5.
